// File: rtl/fetch_queue_if.sv
// Signal bundle for fetch_queue: instruction-memory port, PC redirect, and the
// valid/ready instruction handshake towards decode.
interface fetch_queue_if #(
  parameter int IW  = 16,
  parameter int PCW = 32
) ();
  logic           imem_rd_en;
  logic [PCW-1:0] imem_addr;
  logic [IW-1:0]  imem_rdata;
  logic           redirect_valid;
  logic [PCW-1:0] redirect_pc;
  logic           out_valid;
  logic           out_ready;
  logic [IW-1:0]  out_instr;
  logic [IW-1:0]  out_imm;
  logic [PCW-1:0] out_pc;
  logic [PCW-1:0] out_next_pc;
  logic           out_long;

  modport master (
    output imem_rd_en, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_imm, out_pc, out_next_pc, out_long,
    input  out_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_imm, out_pc, out_next_pc, out_long,
    output out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: streams words from a 1-cycle-latency memory, assembles
// one/two-word instructions into a small FIFO, and flushes on PC redirect.
module fetch_queue #(
  parameter int             IW       = 16,
  parameter int             PCW      = 32,
  parameter int             DEPTH    = 4,
  parameter int             LONG_BIT = 13,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {ST_OP, ST_IMM} state_e;

  typedef struct packed {
    logic           lng;
    logic [PCW-1:0] pc;
    logic [IW-1:0]  imm;
    logic [IW-1:0]  instr;
  } entry_t;

  state_e         state_q, state_d;
  logic [PCW-1:0] fpc_q, fpc_d;
  logic           pend_q, pend_d;
  logic [PCW-1:0] req_pc_q, req_pc_d;
  logic [IW-1:0]  op_word_q, op_word_d;
  logic [PCW-1:0] op_pc_q, op_pc_d;
  logic [AW-1:0]  head_q, head_d;
  logic [AW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  entry_t         mem_q [DEPTH];

  logic           rd_en;
  logic           valid;
  logic           push;
  logic           pop;
  entry_t         push_entry;
  entry_t         head_entry;
  logic [CW:0]    occupancy;

  // Slots already spoken for: queued entries, the word in flight, and the
  // entry a half-assembled long instruction will produce.
  assign occupancy = {1'b0, count_q} + (CW+1)'(pend_q) + (CW+1)'(state_q == ST_IMM);
  assign rd_en     = rst && !bus.redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign valid     = (count_q != '0);
  assign pop       = valid && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    op_word_d  = op_word_q;
    op_pc_d    = op_pc_q;
    push       = 1'b0;
    push_entry = '0;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fpc_d      = rd_en ? fpc_q + PCW'(1) : fpc_q;
    pend_d     = rd_en;
    req_pc_d   = fpc_q;

    if (pend_q) begin
      if (state_q == ST_OP) begin
        if (bus.imem_rdata[LONG_BIT]) begin
          state_d   = ST_IMM;
          op_word_d = bus.imem_rdata;
          op_pc_d   = req_pc_q;
        end else begin
          push       = 1'b1;
          push_entry = '{lng: 1'b0, pc: req_pc_q, imm: '0, instr: bus.imem_rdata};
        end
      end else begin
        push       = 1'b1;
        push_entry = '{lng: 1'b1, pc: op_pc_q, imm: bus.imem_rdata, instr: op_word_q};
        state_d    = ST_OP;
      end
    end

    // Redirect drops the returning word; a same-cycle pop is subsumed by the flush.
    if (bus.redirect_valid) begin
      state_d = ST_OP;
      push    = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      fpc_d   = bus.redirect_pc;
    end else begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_OP;
      fpc_q     <= RESET_PC;
      pend_q    <= 1'b0;
      req_pc_q  <= RESET_PC;
      op_word_q <= '0;
      op_pc_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      pend_q    <= pend_d;
      req_pc_q  <= req_pc_d;
      op_word_q <= op_word_d;
      op_pc_q   <= op_pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_entry;
  end

  assign head_entry      = mem_q[head_q];
  assign bus.imem_rd_en  = rd_en;
  assign bus.imem_addr   = fpc_q;
  assign bus.out_valid   = valid;
  assign bus.out_instr   = valid ? head_entry.instr : '0;
  assign bus.out_imm     = valid ? head_entry.imm : '0;
  assign bus.out_pc      = valid ? head_entry.pc : '0;
  assign bus.out_long    = valid ? head_entry.lng : 1'b0;
  assign bus.out_next_pc = valid ? head_entry.pc + (head_entry.lng ? PCW'(2) : PCW'(1)) : '0;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a cycle table, directed corner sequences, and
// randomized traffic checked against a program-order model of the instruction stream.
module tb_fetch_queue;
  localparam int          IW       = 16;
  localparam int          PCW      = 32;
  localparam int          DEPTH    = 4;
  localparam int          LONG_BIT = 13;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic        rd_en;
    logic [31:0] addr;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    logic [31:0] nxt;
    logic        lng;
  } outs_t;

  typedef struct packed {
    logic  rstn;
    logic  rdy;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_queue_if #(.IW(IW), .PCW(PCW)) bus ();

  fetch_queue #(
    .IW(IW), .PCW(PCW), .DEPTH(DEPTH), .LONG_BIT(LONG_BIT), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];

  always @(posedge clk) begin
    if (bus.imem_rd_en === 1'b1) bus.imem_rdata <= mem[bus.imem_addr[7:0]];
  end

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          n_acc = 0;
  int          viol = 0;
  int          cyc = 0;
  int          acc0;
  int          gaps;
  logic [31:0] model_pc = RESET_PC;
  logic        prev_redir = 1'b0;
  vec_t        vecs [7];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Instruction located at word address p, derived from memory contents alone.
  function automatic logic [96:0] model_rec(input logic [31:0] p);
    logic [15:0] op;
    logic [15:0] imm;
    logic [31:0] p1;
    logic        lng;
    op  = mem[p[7:0]];
    lng = op[LONG_BIT];
    p1  = p + 32'd1;
    imm = lng ? mem[p1[7:0]] : 16'h0;
    return {op, imm, p, p + (lng ? 32'd2 : 32'd1), lng};
  endfunction

  function automatic logic [96:0] head_rec();
    return {bus.out_instr, bus.out_imm, bus.out_pc, bus.out_next_pc, bus.out_long};
  endfunction

  function automatic outs_t outs_rec();
    return '{rd_en: bus.imem_rd_en, addr: bus.imem_addr, valid: bus.out_valid,
             instr: bus.out_instr, imm: bus.out_imm, pc: bus.out_pc,
             nxt: bus.out_next_pc, lng: bus.out_long};
  endfunction

  function automatic vec_t mk_vec(input logic rstn, input logic rdy, input logic rd_en,
                                  input logic [31:0] addr, input logic valid,
                                  input logic [15:0] instr, input logic [15:0] imm,
                                  input logic [31:0] pc, input logic [31:0] nxt,
                                  input logic lng);
    return '{rstn: rstn, rdy: rdy,
             exp: '{rd_en: rd_en, addr: addr, valid: valid, instr: instr, imm: imm,
                    pc: pc, nxt: nxt, lng: lng}};
  endfunction

  // One clock cycle: drive inputs after the falling edge, then observe and score.
  task automatic step(input logic rstn, input logic rdy, input logic redir, input logic [31:0] rpc);
    logic [96:0] exp_rec;
    @(negedge clk);
    rst                = rstn;
    bus.out_ready      = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    if ((!rstn || redir) && bus.imem_rd_en === 1'b1) viol++;
    if (prev_redir && bus.out_valid === 1'b1) viol++;
    if (rstn && rdy && bus.out_valid === 1'b1) begin
      exp_rec = model_rec(model_pc);
      check($sformatf("accept c%0d", cyc), 160'(head_rec()), 160'(exp_rec));
      model_pc = exp_rec[32:1];
      n_acc++;
    end
    if (!rstn) model_pc = RESET_PC;
    else if (redir) model_pc = rpc;
    prev_redir = redir && rstn;
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic init_mem_default();
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
  endtask

  initial begin
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Cycle table: reset row, then cycles 0..5 after release with out_ready high.
    init_mem_default();
    mem[0] = 16'h3811;
    mem[1] = 16'h0004;
    mem[2] = 16'h0100;
    vecs[0] = mk_vec(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 16'h0,    16'h0,    32'h0, 32'h0, 1'b0);
    vecs[1] = mk_vec(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 16'h0,    16'h0,    32'h0, 32'h0, 1'b0);
    vecs[2] = mk_vec(1'b1, 1'b1, 1'b1, 32'h1, 1'b0, 16'h0,    16'h0,    32'h0, 32'h0, 1'b0);
    vecs[3] = mk_vec(1'b1, 1'b1, 1'b1, 32'h2, 1'b0, 16'h0,    16'h0,    32'h0, 32'h0, 1'b0);
    vecs[4] = mk_vec(1'b1, 1'b1, 1'b1, 32'h3, 1'b1, 16'h3811, 16'h0004, 32'h0, 32'h2, 1'b1);
    vecs[5] = mk_vec(1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 16'h0100, 16'h0,    32'h2, 32'h3, 1'b0);
    vecs[6] = mk_vec(1'b1, 1'b1, 1'b1, 32'h5, 1'b1, 16'h1003, 16'h0,    32'h3, 32'h4, 1'b0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].rstn, vecs[i].rdy, 1'b0, 32'h0);
      check($sformatf("vec%0d", i), 160'(outs_rec()), 160'(vecs[i].exp));
    end

    // Stall until the queue fills, then drain ten one-word instructions.
    init_mem_default();
    do_reset();
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_rd_en", 160'(bus.imem_rd_en), 160'(1'b0));
    check("stall_addr",  160'(bus.imem_addr),  160'(32'd4));
    check("stall_valid", 160'(bus.out_valid),  160'(1'b1));
    acc0 = n_acc;
    gaps = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      if (bus.out_valid !== 1'b1) gaps++;
    end
    check("stall_delivered", 160'(n_acc - acc0), 160'(10));
    check("stall_gaps",      160'(gaps),         160'(0));

    // Redirect while assembling a long instruction with two entries queued.
    init_mem_default();
    mem[2] = 16'h2002;
    mem[3] = 16'h0033;
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h40);
    check("rimm_pre_valid", 160'(bus.out_valid), 160'(1'b1));
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("rimm_flush", 160'(bus.out_valid), 160'(1'b0));
    check("rimm_issue", 160'({bus.imem_rd_en, bus.imem_addr}), 160'({1'b1, 32'h40}));
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("rimm_r2_valid", 160'(bus.out_valid), 160'(1'b0));
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("rimm_r3_head", 160'({bus.out_valid, bus.out_pc}), 160'({1'b1, 32'h40}));
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with a head handshake.
    acc0 = n_acc;
    step(1'b1, 1'b1, 1'b1, 32'h80);
    check("hs_valid",    160'(bus.out_valid), 160'(1'b1));
    check("hs_consumed", 160'(n_acc - acc0),  160'(1));
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("hs_empty", 160'(bus.out_valid), 160'(1'b0));
    for (int c = 0; c < 5; c++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset with three entries queued and a word in flight.
    init_mem_default();
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("rmid_pre_valid", 160'(bus.out_valid), 160'(1'b1));
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("rmid_outs", 160'(outs_rec()),
          160'(mk_vec(1'b0, 1'b0, 1'b0, RESET_PC, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0, 1'b0).exp));
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("rmid_restart", 160'({bus.imem_rd_en, bus.imem_addr}), 160'({1'b1, RESET_PC}));
    for (int c = 0; c < 5; c++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap at the top of the address space.
    init_mem_default();
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_issue", 160'({bus.imem_rd_en, bus.imem_addr}), 160'({1'b1, 32'hFFFF_FFFF}));
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_addr", 160'({bus.imem_rd_en, bus.imem_addr}), 160'({1'b1, 32'h0}));
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_head", 160'({bus.out_valid, bus.out_pc, bus.out_next_pc}),
          160'({1'b1, 32'hFFFF_FFFF, 32'h0}));
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic: random program, back-pressure, redirects and resets.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    do_reset();
    acc0 = n_acc;
    for (int c = 0; c < 800; c++) begin
      logic        r_rstn;
      logic        r_rdy;
      logic        r_red;
      logic [31:0] r_pc;
      r_rstn = ($urandom_range(0, 99) != 0);
      r_rdy  = ($urandom_range(0, 9) < 7);
      r_red  = ($urandom_range(0, 19) == 0);
      r_pc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 2))
                                           : 32'($urandom_range(0, 255));
      step(r_rstn, r_rdy, r_red, r_pc);
    end
    check("rand_progress",   160'((n_acc - acc0) >= 100), 160'(1'b1));
    check("rule_violations", 160'(viol),                  160'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
